// File: rtl/stream_merge_2to1_if.sv
// Handshake bundle for the 2:1 packet-aware stream merger: two input streams
// and one merged output stream carrying the source index of each beat.
interface stream_merge_2to1_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in0_valid;
  logic             in0_ready;
  logic [WIDTH-1:0] in0_data;
  logic             in0_last;
  logic             in1_valid;
  logic             in1_ready;
  logic [WIDTH-1:0] in1_data;
  logic             in1_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_src;

  modport master (
    output in0_valid, in0_data, in0_last,
    input  in0_ready,
    output in1_valid, in1_data, in1_last,
    input  in1_ready,
    input  out_valid, out_data, out_last, out_src,
    output out_ready
  );

  modport slave (
    input  in0_valid, in0_data, in0_last,
    output in0_ready,
    input  in1_valid, in1_data, in1_last,
    output in1_ready,
    output out_valid, out_data, out_last, out_src,
    input  out_ready
  );
endinterface

// File: rtl/stream_merge_2to1.sv
// Merges two packet streams into one without interleaving packets; each input
// has a 2-entry FIFO, output is a single register, round-robin between packets.
module stream_merge_2to1 #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  stream_merge_2to1_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} state_t;

  state_t           state, state_next;
  logic             ptr;
  logic [1:0]       in_valid, in_last;
  logic [WIDTH-1:0] in_data   [2];
  logic [WIDTH-1:0] mem_data  [2][2];
  logic             mem_last  [2][2];
  logic [1:0]       rd_ptr, wr_ptr;
  logic [1:0]       count      [2];
  logic [1:0]       count_next [2];
  logic [1:0]       ready_q, push, pop, non_empty, head_last;
  logic [WIDTH-1:0] head_data [2];
  logic             load, sel, eligible;
  logic             out_valid_q, out_last_q, out_src_q;
  logic [WIDTH-1:0] out_data_q;

  always_comb begin
    in_valid   = {bus.in1_valid, bus.in0_valid};
    in_last    = {bus.in1_last, bus.in0_last};
    in_data[0] = bus.in0_data;
    in_data[1] = bus.in1_data;
  end

  assign load = !out_valid_q || bus.out_ready;

  // Push is gated by the registered ready so a full FIFO never accepts,
  // even when it is being popped in the same cycle.
  always_comb begin
    non_empty  = '0;
    head_last  = '0;
    push       = '0;
    pop        = '0;
    head_data  = '{default: '0};
    count_next = '{default: '0};
    for (int unsigned i = 0; i < 2; i++) begin
      non_empty[i] = (count[i] != 2'd0);
      head_data[i] = mem_data[i][rd_ptr[i]];
      head_last[i] = mem_last[i][rd_ptr[i]];
      push[i]      = in_valid[i] && ready_q[i];
      pop[i]       = load && eligible && (sel == i[0]);
      unique case ({push[i], pop[i]})
        2'b10:   count_next[i] = count[i] + 2'd1;
        2'b01:   count_next[i] = count[i] - 2'd1;
        default: count_next[i] = count[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '{default: '0};
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      ready_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        count[i]   <= count_next[i];
        ready_q[i] <= (count_next[i] != 2'd2);
        if (push[i]) wr_ptr[i] <= ~wr_ptr[i];
        if (pop[i])  rd_ptr[i] <= ~rd_ptr[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i]) begin
        mem_data[i][wr_ptr[i]] <= in_data[i];
        mem_last[i][wr_ptr[i]] <= in_last[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 1'b0;
    end else begin
      state <= state_next;
      if (load && eligible && head_last[sel]) ptr <= ~sel;
    end
  end

  always_comb begin
    state_next = state;
    if (load && eligible) begin
      if (head_last[sel]) state_next = IDLE;
      else                state_next = sel ? LOCK1 : LOCK0;
    end
  end

  // While locked, only the owning port may feed the output.
  always_comb begin
    sel      = 1'b0;
    eligible = 1'b0;
    unique case (state)
      IDLE: begin
        eligible = non_empty[0] || non_empty[1];
        sel      = (non_empty[0] && non_empty[1]) ? ptr : non_empty[1];
      end
      LOCK0: begin
        sel      = 1'b0;
        eligible = non_empty[0];
      end
      LOCK1: begin
        sel      = 1'b1;
        eligible = non_empty[1];
      end
      default: begin
        sel      = 1'b0;
        eligible = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= 1'b0;
    end else if (load) begin
      out_valid_q <= eligible;
      if (eligible) begin
        out_data_q <= head_data[sel];
        out_last_q <= head_last[sel];
        out_src_q  <= sel;
      end
    end
  end

  assign bus.in0_ready = ready_q[0];
  assign bus.in1_ready = ready_q[1];
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_stream_merge_2to1.sv
// Directed bench for stream_merge_2to1: a per-cycle vector table plus
// hand-written sequences for packet lock, backpressure and mid-packet reset.
module tb_stream_merge_2to1;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  stream_merge_2to1_if #(.WIDTH(8)) bus ();

  stream_merge_2to1 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       ordy;
    logic       r0;
    logic       r1;
    logic       ov;
    logic [7:0] od;
    logic       ol;
    logic       os;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic rst, input logic v0, input logic [7:0] d0, input logic l0,
                         input logic v1, input logic [7:0] d1, input logic l1, input logic ordy,
                         input logic r0, input logic r1, input logic ov, input logic [7:0] od,
                         input logic ol, input logic os);
    vec_t row;
    row.rst = rst; row.v0 = v0; row.d0 = d0; row.l0 = l0;
    row.v1 = v1; row.d1 = d1; row.l1 = l1; row.ordy = ordy;
    row.r0 = r0; row.r1 = r1; row.ov = ov; row.od = od; row.ol = ol; row.os = os;
    tbl.push_back(row);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, want);
    end
  endtask

  task automatic set_in(input logic v0, input logic [7:0] d0, input logic l0,
                        input logic v1, input logic [7:0] d1, input logic l1, input logic ordy);
    bus.in0_valid = v0; bus.in0_data = d0; bus.in0_last = l0;
    bus.in1_valid = v1; bus.in1_data = d1; bus.in1_last = l1;
    bus.out_ready = ordy;
  endtask

  task automatic step(input logic v0, input logic [7:0] d0, input logic l0,
                      input logic v1, input logic [7:0] d1, input logic l1, input logic ordy);
    @(posedge clk);
    #1;
    set_in(v0, d0, l0, v1, d1, l1, ordy);
    @(negedge clk);
  endtask

  task automatic exp_out(input string name, input logic ov, input logic [7:0] od,
                         input logic ol, input logic os);
    logic [10:0] a, w;
    a = {bus.out_valid, bus.out_data, bus.out_last, bus.out_src};
    w = {ov, od, ol, os};
    if (!ov) begin
      a[9:0] = '0;
      w[9:0] = '0;
    end
    chk(name, {21'd0, a}, {21'd0, w});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_in(0, 8'h00, 0, 0, 8'h00, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [12:0] act, want;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    set_in(0, 8'h00, 0, 0, 8'h00, 0, 1);

    // rst v0 d0 l0 v1 d1 l1 ordy | r0 r1 ov od ol os
    add_row(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0);
    add_row(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0);
    add_row(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0);
    add_row(0, 1, 8'hA0, 1, 1, 8'hB0, 1, 1,  1, 1, 0, 8'h00, 0, 0);
    add_row(0, 1, 8'hA1, 1, 1, 8'hB1, 1, 1,  1, 1, 0, 8'h00, 0, 0);
    add_row(0, 1, 8'hA2, 1, 1, 8'hB2, 1, 1,  1, 0, 1, 8'hA0, 1, 0);
    add_row(0, 1, 8'hA3, 1, 1, 8'hB2, 1, 1,  0, 1, 1, 8'hB0, 1, 1);
    add_row(0, 1, 8'hA3, 1, 1, 8'hB3, 1, 1,  1, 0, 1, 8'hA1, 1, 0);
    add_row(0, 1, 8'hA4, 1, 1, 8'hB3, 1, 1,  0, 1, 1, 8'hB1, 1, 1);
    add_row(0, 1, 8'hA4, 1, 1, 8'hB4, 1, 1,  1, 0, 1, 8'hA2, 1, 0);
    add_row(0, 1, 8'hA5, 1, 1, 8'hB4, 1, 1,  0, 1, 1, 8'hB2, 1, 1);
    add_row(1, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0);
    add_row(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  0, 0, 0, 8'h00, 0, 0);
    add_row(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 1, 0, 8'h00, 0, 0);
    add_row(0, 1, 8'h11, 1, 0, 8'h00, 0, 1,  1, 1, 0, 8'h00, 0, 0);
    add_row(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 1, 0, 8'h00, 0, 0);
    add_row(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 1, 1, 8'h11, 1, 0);
    add_row(0, 0, 8'h00, 0, 0, 8'h00, 0, 1,  1, 1, 0, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst_n = !tbl[i].rst;
      set_in(tbl[i].v0, tbl[i].d0, tbl[i].l0, tbl[i].v1, tbl[i].d1, tbl[i].l1, tbl[i].ordy);
      @(negedge clk);
      act  = {bus.in0_ready, bus.in1_ready, bus.out_valid, bus.out_data, bus.out_last, bus.out_src};
      want = {tbl[i].r0, tbl[i].r1, tbl[i].ov, tbl[i].od, tbl[i].ol, tbl[i].os};
      if (!(tbl[i].ov || tbl[i].rst)) begin
        act[9:0]  = '0;
        want[9:0] = '0;
      end
      chk($sformatf("row%0d", i), {19'd0, act}, {19'd0, want});
    end

    // Packet lock: in1's single beat waits behind in0's 3-beat packet.
    do_reset();
    step(1, 8'h01, 0, 1, 8'hF0, 1, 1); exp_out("lock_c0", 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("lock_c1", 0, 8'h00, 0, 0);
    step(1, 8'h02, 0, 0, 8'h00, 0, 1); exp_out("lock_c2", 1, 8'h01, 0, 0);
    step(1, 8'h03, 1, 0, 8'h00, 0, 1); exp_out("lock_gap", 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("lock_c4", 1, 8'h02, 0, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("lock_c5", 1, 8'h03, 1, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("lock_c6", 1, 8'hF0, 1, 1);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("lock_c7", 0, 8'h00, 0, 0);

    // Backpressure: out_ready low for six cycles while in1 pushes four beats.
    do_reset();
    step(0, 8'h00, 0, 1, 8'h51, 1, 0); chk("bp_rdy_c0", {31'd0, bus.in1_ready}, 32'd1);
    exp_out("bp_c0", 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1, 8'h52, 1, 0); exp_out("bp_c1", 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1, 8'h53, 1, 0); chk("bp_rdy_c2", {31'd0, bus.in1_ready}, 32'd1);
    exp_out("bp_c2", 1, 8'h51, 1, 1);
    for (int k = 3; k <= 5; k++) begin
      step(0, 8'h00, 0, 1, 8'h54, 1, 0);
      chk($sformatf("bp_rdy_c%0d", k), {31'd0, bus.in1_ready}, 32'd0);
      exp_out($sformatf("bp_hold_c%0d", k), 1, 8'h51, 1, 1);
    end
    step(0, 8'h00, 0, 1, 8'h54, 1, 1); chk("bp_rdy_c6", {31'd0, bus.in1_ready}, 32'd0);
    exp_out("bp_c6", 1, 8'h51, 1, 1);
    step(0, 8'h00, 0, 1, 8'h54, 1, 1); chk("bp_rdy_c7", {31'd0, bus.in1_ready}, 32'd1);
    exp_out("bp_c7", 1, 8'h52, 1, 1);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("bp_c8", 1, 8'h53, 1, 1);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("bp_c9", 1, 8'h54, 1, 1);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("bp_c10", 0, 8'h00, 0, 0);

    // Reset during beat 2 of a 4-beat in0 packet; the buffered beat must vanish.
    do_reset();
    step(1, 8'hC1, 0, 0, 8'h00, 0, 1); exp_out("mr_c0", 0, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    set_in(1, 8'hC2, 0, 0, 8'h00, 0, 1);
    @(negedge clk);
    chk("mr_in_reset", {19'd0, bus.in0_ready, bus.in1_ready, bus.out_valid, bus.out_data,
                        bus.out_last, bus.out_src}, 32'd0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("mr_c2", 0, 8'h00, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_rel_rdy", {30'd0, bus.in0_ready, bus.in1_ready}, 32'd0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("mr_c4", 0, 8'h00, 0, 0);
    chk("mr_c4_rdy", {30'd0, bus.in0_ready, bus.in1_ready}, 32'd3);
    step(1, 8'hD1, 0, 0, 8'h00, 0, 1); exp_out("mr_c5", 0, 8'h00, 0, 0);
    step(1, 8'hD2, 1, 0, 8'h00, 0, 1); exp_out("mr_c6", 0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("mr_c7", 1, 8'hD1, 0, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("mr_c8", 1, 8'hD2, 1, 0);
    step(0, 8'h00, 0, 0, 8'h00, 0, 1); exp_out("mr_c9", 0, 8'h00, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_merge_2to1.md
STREAM_MERGE_2TO1 -- requirements
Module: stream_merge_2to1

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data width in bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: in0_valid input 1, in0_ready output 1, in0_data input WIDTH, in0_last input 1  stream 0, last marks final beat of packet.
REQ-005 SHALL have ports: in1_valid input 1, in1_ready output 1, in1_data input WIDTH, in1_last input 1  stream 1, same meaning.
REQ-006 SHALL have ports: out_valid output 1, out_ready input 1, out_data output WIDTH, out_last output 1, out_src output 1  merged stream; out_src = source port index of beat.

Function
REQ-007 SHALL transfer a beat on any port in a cycle where valid and ready are both 1.
REQ-008 SHALL buffer each input in its own 2-entry FIFO with a registered 2-bit count (0..2), holding data and last.
REQ-009 SHALL drive inN_ready = (countN != 2) from registers only; there is no combinational path from out_ready to any inN_ready.
REQ-010 SHALL NOT accept a push into a full FIFO even if it is popped in the same cycle; push and pop together on a non-full FIFO leave count unchanged.
REQ-011 SHALL hold a single output register (out_valid, out_data, out_last, out_src) that loads when out_valid == 0 or out_ready == 1.
REQ-012 SHALL, on a load, pop exactly one beat from the selected FIFO; if no FIFO is eligible, out_valid goes to 0 on that load.
REQ-013 SHALL keep out_data, out_last, out_src stable while out_valid == 1 and out_ready == 0.
REQ-014 SHALL have minimum latency 2: beat accepted at cycle N is on out_valid at cycle N+2 when the output is free.
REQ-015 SHALL sustain 1 beat/cycle on out when out_ready is held 1 and inputs keep FIFOs non-empty.
REQ-016 SHALL keep a state machine IDLE, LOCK0, LOCK1.
REQ-017 SHALL, in IDLE, select among non-empty FIFOs by a priority pointer ptr: if both are non-empty select port ptr; if only one is non-empty select it.
REQ-018 SHALL go IDLE -> LOCKp when a beat from port p with last == 0 is loaded; stay IDLE when the loaded beat has last == 1.
REQ-019 SHALL, in LOCKp, select only port p; an empty FIFO p stalls the output (out_valid drops) even if the other FIFO holds data.
REQ-020 SHALL go LOCKp -> IDLE when the beat loaded from port p has last == 1.
REQ-021 SHALL set ptr to ~p when a last == 1 beat from port p is loaded; ptr is otherwise unchanged.
REQ-022 SHALL never interleave beats of two packets on out.

Reset
REQ-023 SHALL, while rst_n == 0, force: both counts 0, in0_ready = in1_ready = 0, out_valid = 0, out_data = 0, out_last = 0, out_src = 0, state IDLE, ptr = 0.
REQ-024 SHALL drive in0_ready = in1_ready = 1 from the first rising edge after rst_n deasserts.
REQ-025 SHALL discard all buffered beats and any partial packet on reset mid-operation, with no partial beat after release.

Verification
REQ-026 Single beats: in0 data 0x11 last 1 at cycle 0, out_ready 1 -> out_valid 1, out_data 0x11, out_src 0, out_last 1 at cycle 2.
REQ-027 Round-robin: both ports push single-beat packets every cycle (in0 0xA0.., in1 0xB0..), out_ready 1 -> out_src alternates 0,1,0,1, first is 0 after reset.
REQ-028 Packet lock: in0 sends 3-beat packet 0x01,0x02,0x03 (last on 0x03) with one idle cycle after 0x01, in1 sends 0xF0 last 1 -> out shows 0x01,0x02,0x03 contiguous by source, then 0xF0; out_valid 0 during the in0 gap.
REQ-029 Backpressure: out_ready 0 for 6 cycles while in1 pushes 0x51..0x54 -> in1_ready goes 0 after 2 buffered plus 1 in the output register; out_data holds 0x51; on release out gives 0x51,0x52,0x53,0x54 in order with no loss.
REQ-030 Reset mid-packet: rst_n low during beat 2 of a 4-beat in0 packet -> out_valid 0 during reset and after release until a new beat arrives; next packet is output intact with out_src 0.
